// File: rtl/lpi_qch_pkg.sv
// ---------------------------------------------------------------------------
// lpi_qch_pkg
// Shared definitions for the LPI Q-channel controller.
//   qch_state_e  : controller FSM states with their fixed encodings
//   Q_RUN        : level of the active-low Q-channel handshake wires when the
//                  isolated domain is running (qreqn/qacceptn deasserted)
//   Q_STOPPED    : level of those wires when quiescence is requested/granted
//   qreqn_for    : qreqn level the controller presents in a given state
//   clk_en_for   : clock-gate enable the controller presents in a given state
// ---------------------------------------------------------------------------
package lpi_qch_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_REQ      = 3'd1,
        ST_STOPPED  = 3'd2,
        ST_EXIT     = 3'd3,
        ST_DENIED   = 3'd4,
        ST_CONTINUE = 3'd5
    } qch_state_e;

    localparam logic Q_RUN     = 1'b1;
    localparam logic Q_STOPPED = 1'b0;

    // The request is held low from the moment it is raised until the isolator
    // has either stopped the domain or the deny has been acknowledged.
    function automatic logic qreqn_for(input qch_state_e s);
        logic v;
        v = Q_RUN;
        if ((s == ST_REQ) || (s == ST_STOPPED) || (s == ST_DENIED)) begin
            v = Q_STOPPED;
        end
        return v;
    endfunction

    // The domain clock is only gated while the handshake says it is stopped.
    function automatic logic clk_en_for(input qch_state_e s);
        return (s != ST_STOPPED);
    endfunction

endpackage

// File: rtl/lpi_idle_counter.sv
// ---------------------------------------------------------------------------
// lpi_idle_counter
// Counts consecutive idle cycles while the controller sits in RUN and flags
// when the next idle edge would complete the programmed threshold.
// Ports:
//   i_clk      : clock
//   i_rst_n    : asynchronous active-low reset
//   i_run      : controller is in RUN and staying there this edge
//   i_active   : device activity (qactive)
//   i_thresh   : idle threshold, 0 disables the hit flag
//   o_hit      : counter has reached threshold-1 (or above after a threshold
//                reduction), so an idle edge now completes the idle period
// ---------------------------------------------------------------------------
module lpi_idle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_active,
    input  logic [CNT_W-1:0] i_thresh,
    output logic             o_hit
);

    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] w_thresh_m1;

    assign w_thresh_m1 = i_thresh - CNT_W'(1);

    // Using >= rather than == lets a threshold lowered below the current
    // count take effect on the very next idle edge.
    assign o_hit = (i_thresh != '0) && (r_idle_cnt >= w_thresh_m1);

    // Clear outside RUN or on activity; otherwise count up, clamped to the
    // threshold so a lowered threshold also pulls the count down with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idle_cnt <= '0;
        end else if (!i_run || i_active) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt >= i_thresh) begin
            r_idle_cnt <= i_thresh;
        end else begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lpi_qch_controller.sv
// ---------------------------------------------------------------------------
// lpi_qch_controller
// Low-power-interface controller driving a Q-channel isolator: requests
// quiescence after a run of idle cycles, gates the domain clock while the
// isolator reports it stopped, and wakes it on activity or software request.
// Ports:
//   pclk_i        : clock
//   presetn_i     : asynchronous active-low reset
//   en_i          : permits new quiescence requests
//   idle_thresh_i : consecutive idle cycles before a request (0 = never)
//   wake_i        : software wake request
//   qactive_i     : device activity from the isolator
//   qacceptn_i    : accept from the isolator (active low)
//   qdeny_i       : deny from the isolator
//   qreqn_o       : quiescence request to the isolator (active low)
//   clk_en_o      : clock-gate enable for the isolated domain
//   state_o       : current FSM state encoding
//   deny_cnt_o    : saturating count of denied requests
//   proto_err_o   : sticky Q-channel protocol violation flag
// ---------------------------------------------------------------------------
module lpi_qch_controller
    import lpi_qch_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DCNT_W = 8
) (
    input  logic              pclk_i,
    input  logic              presetn_i,
    input  logic              en_i,
    input  logic [CNT_W-1:0]  idle_thresh_i,
    input  logic              wake_i,
    input  logic              qactive_i,
    input  logic              qacceptn_i,
    input  logic              qdeny_i,
    output logic              qreqn_o,
    output logic              clk_en_o,
    output logic [2:0]        state_o,
    output logic [DCNT_W-1:0] deny_cnt_o,
    output logic              proto_err_o
);

    qch_state_e        r_state;
    qch_state_e        w_next_state;
    logic              w_idle_hit;
    logic              w_run_count;
    logic              w_err_set;
    logic              w_deny_evt;
    logic              r_qreqn;
    logic              r_clk_en;
    logic [DCNT_W-1:0] r_deny_cnt;
    logic              r_proto_err;

    // Counting only continues while RUN is kept; leaving RUN clears it.
    assign w_run_count = (r_state == ST_RUN) && (w_next_state == ST_RUN);

    lpi_idle_counter #(
        .CNT_W (CNT_W)
    ) u_idle_counter (
        .i_clk    (pclk_i),
        .i_rst_n  (presetn_i),
        .i_run    (w_run_count),
        .i_active (qactive_i),
        .i_thresh (idle_thresh_i),
        .o_hit    (w_idle_hit)
    );

    // Next-state, deny event and protocol-error detection.
    always_comb begin
        w_next_state = r_state;
        w_err_set    = 1'b0;
        w_deny_evt   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (qacceptn_i == Q_STOPPED) begin
                    w_err_set = 1'b1;
                end
                if (!qactive_i && en_i && !wake_i && w_idle_hit) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                // Once raised, the request cannot be withdrawn; only the
                // isolator's answer moves us on.
                if ((qacceptn_i == Q_STOPPED) && !qdeny_i) begin
                    w_next_state = ST_STOPPED;
                end else if ((qacceptn_i == Q_RUN) && qdeny_i) begin
                    w_next_state = ST_DENIED;
                    w_deny_evt   = 1'b1;
                end else if ((qacceptn_i == Q_STOPPED) && qdeny_i) begin
                    w_err_set = 1'b1;
                end
            end
            ST_STOPPED: begin
                if (qdeny_i) begin
                    w_err_set = 1'b1;
                end
                if (qactive_i || wake_i || !en_i) begin
                    w_next_state = ST_EXIT;
                end
            end
            ST_EXIT: begin
                if (qdeny_i) begin
                    w_err_set = 1'b1;
                end
                if (qacceptn_i == Q_RUN) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DENIED: begin
                if (qacceptn_i == Q_STOPPED) begin
                    w_err_set = 1'b1;
                end
                w_next_state = ST_CONTINUE;
            end
            ST_CONTINUE: begin
                if (qacceptn_i == Q_STOPPED) begin
                    w_err_set = 1'b1;
                end
                if (!qdeny_i) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // State register; handshake outputs are registered from the next state so
    // they change on the same edge as the state they belong to.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            r_state  <= ST_RUN;
            r_qreqn  <= Q_RUN;
            r_clk_en <= 1'b1;
        end else begin
            r_state  <= w_next_state;
            r_qreqn  <= qreqn_for(w_next_state);
            r_clk_en <= clk_en_for(w_next_state);
        end
    end

    // Deny counter saturates rather than wrapping so a stuck denier stays
    // visible; the error flag is sticky until reset.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            r_deny_cnt  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_deny_evt && (r_deny_cnt != '1)) begin
                r_deny_cnt <= r_deny_cnt + DCNT_W'(1);
            end
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign qreqn_o     = r_qreqn;
    assign clk_en_o    = r_clk_en;
    assign state_o     = r_state;
    assign deny_cnt_o  = r_deny_cnt;
    assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_lpi_qch_controller.sv
// ---------------------------------------------------------------------------
// tb_lpi_qch_controller
// Directed bench for lpi_qch_controller: a table of per-edge input/expected
// records walks a full stop/wake and deny handshake, then hand-written
// sequences cover deny saturation, threshold changes, reset mid-handshake,
// non-requesting activity patterns and the sticky protocol error.
// ---------------------------------------------------------------------------
module tb_lpi_qch_controller;

    localparam int CNT_W  = 16;
    localparam int DCNT_W = 8;

    logic              pclk = 1'b0;
    logic              presetn;
    logic              en;
    logic [CNT_W-1:0]  idleThresh;
    logic              wake;
    logic              qactive;
    logic              qacceptn;
    logic              qdeny;
    logic              qreqn;
    logic              clkEn;
    logic [2:0]        stateOut;
    logic [DCNT_W-1:0] denyCnt;
    logic              protoErr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic en;
        logic wake;
        logic qactive;
        logic qacceptn;
        logic qdeny;
        int   expState;
        int   expQreqn;
        int   expClkEn;
        int   expDeny;
        int   expErr;
    } vec_t;

    vec_t vecs[$];

    lpi_qch_controller #(
        .CNT_W  (CNT_W),
        .DCNT_W (DCNT_W)
    ) dut (
        .pclk_i        (pclk),
        .presetn_i     (presetn),
        .en_i          (en),
        .idle_thresh_i (idleThresh),
        .wake_i        (wake),
        .qactive_i     (qactive),
        .qacceptn_i    (qacceptn),
        .qdeny_i       (qdeny),
        .qreqn_o       (qreqn),
        .clk_en_o      (clkEn),
        .state_o       (stateOut),
        .deny_cnt_o    (denyCnt),
        .proto_err_o   (protoErr)
    );

    // 10 ns clock
    always #5 pclk = ~pclk;

    // Guard against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: run did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int st, input int qr,
                            input int ce, input int dc, input int pe);
        checkOutput({tag, ".state"},    int'(stateOut), st);
        checkOutput({tag, ".qreqn"},    int'(qreqn),    qr);
        checkOutput({tag, ".clk_en"},   int'(clkEn),    ce);
        checkOutput({tag, ".deny_cnt"}, int'(denyCnt),  dc);
        checkOutput({tag, ".err"},      int'(protoErr), pe);
    endtask

    task automatic applyStimulus(input logic e, input logic w, input logic a,
                                 input logic acc, input logic d);
        en       = e;
        wake     = w;
        qactive  = a;
        qacceptn = acc;
        qdeny    = d;
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic addVec(input logic e, input logic w, input logic a, input logic acc,
                          input logic d, input int st, input int qr, input int ce,
                          input int dc, input int pe);
        vec_t v;
        v.en = e; v.wake = w; v.qactive = a; v.qacceptn = acc; v.qdeny = d;
        v.expState = st; v.expQreqn = qr; v.expClkEn = ce; v.expDeny = dc; v.expErr = pe;
        vecs.push_back(v);
    endtask

    initial begin
        // Table: idle_thresh=4. en wake qactive qacceptn qdeny | state qreqn clk_en deny err
        addVec(1, 0, 0, 1, 0,  0, 1, 1, 0, 0);  // idle edge 1
        addVec(1, 0, 0, 1, 0,  0, 1, 1, 0, 0);  // idle edge 2
        addVec(1, 0, 0, 1, 0,  0, 1, 1, 0, 0);  // idle edge 3
        addVec(1, 0, 0, 1, 0,  1, 0, 1, 0, 0);  // idle edge 4 -> REQ
        addVec(0, 0, 1, 1, 0,  1, 0, 1, 0, 0);  // en=0/active in REQ: no withdrawal
        addVec(1, 0, 0, 0, 0,  2, 0, 0, 0, 0);  // accept -> STOPPED
        addVec(1, 0, 0, 0, 0,  2, 0, 0, 0, 0);  // stays stopped
        addVec(1, 0, 1, 0, 0,  3, 1, 1, 0, 0);  // activity -> EXIT
        addVec(1, 0, 1, 0, 0,  3, 1, 1, 0, 0);  // waits for qacceptn
        addVec(1, 0, 1, 1, 0,  0, 1, 1, 0, 0);  // qacceptn high -> RUN
        addVec(1, 0, 0, 1, 0,  0, 1, 1, 0, 0);
        addVec(1, 0, 0, 1, 0,  0, 1, 1, 0, 0);
        addVec(1, 0, 0, 1, 0,  0, 1, 1, 0, 0);
        addVec(1, 0, 0, 1, 0,  1, 0, 1, 0, 0);  // REQ again
        addVec(1, 0, 0, 1, 1,  4, 0, 1, 1, 0);  // deny -> DENIED
        addVec(1, 0, 0, 1, 1,  5, 1, 1, 1, 0);  // -> CONTINUE
        addVec(1, 0, 0, 1, 1,  5, 1, 1, 1, 0);  // holds while qdeny
        addVec(1, 0, 1, 1, 0,  0, 1, 1, 1, 0);  // qdeny low -> RUN

        // Reset
        presetn    = 1'b0;
        idleThresh = CNT_W'(4);
        applyStimulus(1, 0, 1, 1, 0);
        repeat (2) @(posedge pclk);
        #1;
        checkAll("reset", 0, 1, 1, 0, 0);
        presetn = 1'b1;

        // Table walk
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].wake, vecs[i].qactive,
                          vecs[i].qacceptn, vecs[i].qdeny);
            tick();
            checkAll($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expQreqn,
                     vecs[i].expClkEn, vecs[i].expDeny, vecs[i].expErr);
        end

        // Deny 299 more times with threshold 1; count saturates at 255
        idleThresh = CNT_W'(1);
        for (int i = 0; i < 299; i++) begin
            applyStimulus(1, 0, 0, 1, 0);
            tick();
            checkOutput($sformatf("denyloop%0d.req", i), int'(stateOut), 1);
            qdeny = 1'b1;
            tick();
            tick();
            checkOutput($sformatf("denyloop%0d.cont", i), int'(stateOut), 5);
            qdeny   = 1'b0;
            qactive = 1'b1;
            tick();
            if (i == 0) begin
                checkOutput("denyloop0.cnt", int'(denyCnt), 2);
            end
        end
        checkAll("denysat", 0, 1, 1, 255, 0);

        // Lowering the threshold below the current count requests next idle edge
        idleThresh = CNT_W'(8);
        qactive    = 1'b0;
        repeat (5) tick();
        checkAll("thr8.5idle", 0, 1, 1, 255, 0);
        idleThresh = CNT_W'(3);
        tick();
        checkAll("thr3.lowered", 1, 0, 1, 255, 0);
        qacceptn = 1'b0;
        tick();
        checkAll("thr3.stopped", 2, 0, 0, 255, 0);

        // Asynchronous reset while stopped
        #2;
        presetn = 1'b0;
        #1;
        checkAll("asyncreset", 0, 1, 1, 0, 0);
        qacceptn = 1'b1;
        qactive  = 1'b1;
        tick();
        presetn = 1'b0;
        presetn = 1'b1;

        // Threshold 3 with activity every second cycle never requests
        idleThresh = CNT_W'(3);
        for (int i = 0; i < 20; i++) begin
            qactive = (i % 2) == 1;
            tick();
            checkOutput($sformatf("pulse%0d.qreqn", i), int'(qreqn), 1);
        end
        checkOutput("pulse.state", int'(stateOut), 0);

        // Threshold 0 never requests
        idleThresh = '0;
        qactive    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput($sformatf("thr0_%0d.qreqn", i), int'(qreqn), 1);
        end

        // Accept and deny together in REQ: sticky error, stay in REQ
        idleThresh = CNT_W'(1);
        applyStimulus(1, 0, 0, 1, 0);
        tick();
        checkAll("perr.req", 1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        tick();
        checkAll("perr.both", 1, 0, 1, 0, 1);
        applyStimulus(0, 0, 1, 1, 0);
        tick();
        checkAll("perr.nowithdraw", 1, 0, 1, 0, 1);
        qdeny = 1'b1;
        tick();
        checkAll("perr.denied", 4, 0, 1, 1, 1);
        tick();
        checkAll("perr.cont", 5, 1, 1, 1, 1);
        qdeny = 1'b0;
        tick();
        checkAll("perr.run", 0, 1, 1, 1, 1);

        // Only reset clears the error
        presetn = 1'b0;
        #1;
        checkAll("perr.reset", 0, 1, 1, 0, 0);
        presetn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lpi_qch_controller.md
LPI_QCH_CONTROLLER -- requirements
Module: lpi_qch_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the idle threshold and the idle counter.
REQ-002 SHALL have parameter DCNT_W, default 8: width of the deny counter.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port pclk_i, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 SHALL have port presetn_i, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port en_i, input, 1 bit: permits new quiescence requests.
REQ-007 SHALL have port idle_thresh_i, input, CNT_W bits: number of consecutive idle cycles before a request; 0 disables requests.
REQ-008 SHALL have port wake_i, input, 1 bit: software wake request.
REQ-009 SHALL have port qactive_i, input, 1 bit: device activity, from the isolator's qactive_o.
REQ-010 SHALL have port qacceptn_i, input, 1 bit: accept, from the isolator's qacceptn_o.
REQ-011 SHALL have port qdeny_i, input, 1 bit: deny, from the isolator's qdeny_o.
REQ-012 SHALL have port qreqn_o, output, 1 bit: quiescence request, driving the isolator's qreqn_i.
REQ-013 SHALL have port clk_en_o, output, 1 bit: clock-gate enable for the isolated domain.
REQ-014 SHALL have port state_o, output, 3 bits: current FSM state encoding.
REQ-015 SHALL have port deny_cnt_o, output, DCNT_W bits: saturating count of denied requests.
REQ-016 SHALL have port proto_err_o, output, 1 bit: sticky Q-channel protocol violation flag.

Function
REQ-017 SHALL implement FSM states with these encodings: RUN=0, REQ=1, STOPPED=2, EXIT=3, DENIED=4, CONTINUE=5.
REQ-018 SHALL register all outputs; qreqn_o SHALL be 0 exactly in states REQ, STOPPED and DENIED.
REQ-019 SHALL drive clk_en_o=0 only in state STOPPED.
REQ-020 SHALL, in RUN, increment idle_cnt on each edge where qactive_i=0, and clear it on each edge where qactive_i=1.
REQ-021 SHALL saturate idle_cnt at idle_thresh_i.
REQ-022 SHALL clear idle_cnt on leaving RUN.
REQ-023 SHALL transition RUN->REQ on the edge where qactive_i=0, en_i=1, wake_i=0, idle_thresh_i!=0 and idle_cnt==idle_thresh_i-1.
REQ-024 SHALL, as a consequence of REQ-023, lower qreqn_o on the Nth consecutive idle edge, where N=idle_thresh_i.
REQ-025 SHALL transition REQ->STOPPED when qacceptn_i=0 and qdeny_i=0.
REQ-026 SHALL transition REQ->DENIED when qdeny_i=1 and qacceptn_i=1.
REQ-027 SHALL increment deny_cnt_o, saturating at all-ones, on each REQ->DENIED transition.
REQ-028 SHALL, in REQ with qacceptn_i=0 and qdeny_i=1 together, set proto_err_o and remain in REQ.
REQ-029 SHALL NOT withdraw a request in REQ: en_i, wake_i and qactive_i are ignored there until accept or deny.
REQ-030 SHALL transition STOPPED->EXIT when qactive_i=1, wake_i=1 or en_i=0.
REQ-031 SHALL raise qreqn_o and clk_en_o on the transition to EXIT.
REQ-032 SHALL transition EXIT->RUN when qacceptn_i=1.
REQ-033 SHALL set proto_err_o if qdeny_i=1 in EXIT or STOPPED.
REQ-034 SHALL transition DENIED->CONTINUE unconditionally after 1 cycle, raising qreqn_o.
REQ-035 SHALL transition CONTINUE->RUN when qdeny_i=0.
REQ-036 SHALL set proto_err_o if qacceptn_i=0 in RUN, DENIED or CONTINUE.
REQ-037 SHALL update idle_thresh_i changes in RUN on the next comparison; a new threshold at or below idle_cnt SHALL trigger a request on the next idle edge.

Reset
REQ-038 SHALL, while presetn_i=0, hold: state=RUN, qreqn_o=1, clk_en_o=1, idle_cnt=0, deny_cnt_o=0, proto_err_o=0.
REQ-039 SHALL treat assertion of reset in any state, including mid-handshake, as an immediate return to RUN values with no handshake completion.
REQ-040 SHALL clear proto_err_o only on reset.

Structure
REQ-041 SHALL place the state enum and its encodings in shared package lpi_qch_pkg.
REQ-042 SHALL place the Q-channel encoding constants, e.g. Q_RUN and Q_STOPPED, in lpi_qch_pkg.
REQ-043 SHALL implement the idle counter (clear, saturate, compare) as sub-module lpi_idle_counter.
REQ-044 SHALL keep the FSM and the deny and error logic in the top module.

Verification
REQ-045 SHALL cover: idle_thresh=4, en=1, qactive held 0 -> qreqn_o falls after the 4th idle edge; qacceptn=0 -> STOPPED, clk_en_o=0.
REQ-046 SHALL cover: STOPPED, then qactive=1 -> EXIT with qreqn_o=1 and clk_en_o=1 next edge; qacceptn=1 -> RUN.
REQ-047 SHALL cover: REQ, then qdeny=1 -> DENIED, then CONTINUE, deny_cnt_o=1; qdeny=0 -> RUN; repeated 300 times -> deny_cnt_o=255.
REQ-048 SHALL cover: idle_thresh=3 with qactive pulsing 1 every 2nd cycle -> qreqn_o stays 1; idle_thresh=0 -> never requests.
REQ-049 SHALL cover: in REQ, qacceptn=0 and qdeny=1 together -> proto_err_o=1 and sticky; en_i=0 in REQ -> no withdrawal.
REQ-050 SHALL cover: presetn_i asserted in STOPPED -> qreqn_o=1, clk_en_o=1, state_o=0 asynchronously.
